seq_shift_add_mult: RTL and testbench

Sequential radix-2 shift-add unsigned multiplier built directly on top of the team's parameterised carry-lookahead adder (cla_Nbit). The multiplier consumes the CLA adder: each iteration performs one N-bit CLA addition of the multiplicand into the upper partial product, then a 1-bit right shift. Start/done handshake toward the surrounding datapath; one product per N iterations.

---
 rtl/mult_pkg.sv | 19 +
 rtl/cla_Nbit.sv | 49 ++++
 rtl/seq_shift_add_mult.sv | 111 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier and its CLA adder.
// Used by seq_shift_add_mult; the EARLY_TERM_EN build option lives in the top file.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // The iteration counter only has to reach n-1, so clog2(n) bits are enough.
  function automatic int cntWidth(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cla_Nbit.sv
// Parameterised carry-lookahead adder: 4-bit lookahead groups chained group to group.
// Widths that are not a multiple of 4 are zero-padded internally.
module cla_Nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int GROUPS = (N + 3) / 4;
  localparam int NP     = GROUPS * 4;

  logic [NP-1:0] aPad, bPad, prop, gen, sumPad;
  logic [NP:0]   carry;

  assign aPad = NP'(a_i);
  assign bPad = NP'(b_i);
  assign prop = aPad ^ bPad;
  assign gen  = aPad & bPad;

  // Every carry inside a group comes straight from the group carry-in; only the group carry ripples.
  always_comb begin : groupCarry
    logic [3:0] p;
    logic [3:0] g;
    logic       c;
    p     = '0;
    g     = '0;
    carry = '0;
    c     = cin_i;
    for (int gi = 0; gi < GROUPS; gi++) begin
      p = prop[4*gi +: 4];
      g = gen[4*gi +: 4];
      carry[4*gi]   = c;
      carry[4*gi+1] = g[0] | (p[0] & c);
      carry[4*gi+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      carry[4*gi+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c);
    end
    carry[NP] = c;
  end

  assign sumPad = prop ^ carry[NP-1:0];
  assign sum_o  = sumPad[N-1:0];
  assign cout_o = carry[N];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential radix-2 shift-add unsigned multiplier; one cla_Nbit addition per iteration.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*N-1:0] product_o
);

  localparam int CW = cntWidth(N);

  state_e           state_q;
  logic [N-1:0]     acc_q, mplr_q, mcand_q;
  logic [CW-1:0]    count_q;
  logic             busy_q, done_q;
  logic [2*N-1:0]   product_q;

  logic [N-1:0]     addend, sum, acc_d, mplr_d;
  logic             cout, finish_d;
  logic [2*N-1:0]   result_d;

  assign addend = mplr_q[0] ? mcand_q : '0;

  cla_Nbit #(.N(N)) uAdd (
    .a_i   (acc_q),
    .b_i   (addend),
    .cin_i (1'b0),
    .sum_o (sum),
    .cout_o(cout)
  );

  // The adder carry becomes the new acc MSB, so the 2N-bit shift never loses a bit.
  assign acc_d  = {cout, sum[N-1:1]};
  assign mplr_d = {sum[0], mplr_q[N-1:1]};

`ifdef EARLY_TERM_EN
  logic [N-1:0] liveBits;
  // Multiplier bits still waiting after this iteration sit at mplr_q[N-1-count:1].
  assign liveBits = (mplr_q >> 1) & ({N{1'b1}} >> (int'(count_q) + 1));
  assign finish_d = (count_q == CW'(N - 1)) || (liveBits == '0);
  assign result_d = {acc_d, mplr_d} >> (CW'(N - 1) - count_q);
`else
  assign finish_d = (count_q == CW'(N - 1));
  assign result_d = {acc_d, mplr_d};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mplr_q    <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mcand_q <= a_i;
            mplr_q  <= b_i;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          mplr_q  <= mplr_d;
          count_q <= count_q + 1'b1;
          if (finish_d) begin
            product_q <= result_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          // busy is already low here, so a waiting start launches the next operation back-to-back.
          if (start_i) begin
            mcand_q <= a_i;
            mplr_q  <= b_i;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult: directed operand pairs with hand-computed products.
// Expected latency follows EARLY_TERM_EN when that macro is defined for the build.
module tb_seq_shift_add_mult;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [N-1:0]   a_i = '0;
  logic [N-1:0]   b_i = '0;
  logic           busy_o, done_o;
  logic [2*N-1:0] product_o;

  typedef struct {
    logic [2*N-1:0] prod;
    int             accEdge;
    int             lat;
  } exp_t;

  exp_t           sbQ[$];
  exp_t           monE;
  int             total = 0;
  int             bad = 0;
  int             edgeCnt = 0;
  logic [2*N-1:0] lastProd = '0;
  logic           prevDone = 1'b0;

  seq_shift_add_mult #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .product_o(product_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Edges from acceptance (inclusive) to the edge that raises done.
  function automatic int expLatency(input logic [N-1:0] b);
`ifdef EARLY_TERM_EN
    int hsb;
    hsb = 0;
    for (int i = 0; i < N; i++) if (b[i]) hsb = i;
    return 2 + hsb;
`else
    return N + 1;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] prod);
    int waitCyc;
    waitCyc = 0;
    @(negedge clk);
    while (busy_o && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (busy_o) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: busy still 1 after %0d cycles, required 0", waitCyc);
      return;
    end
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    sbQ.push_back('{prod, edgeCnt, expLatency(b)});
    start_i = 1'b0;
  endtask

  // Monitor: pops on every done pulse and polices busy/product while an operation is pending.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prevDone) checkOutput("done_pulse_width", 64'(done_o), 64'd0);
      if (done_o) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got done with product 0x%0h, required no done", product_o);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("product", product_o, monE.prod);
          checkOutput("latency", 64'(edgeCnt - monE.accEdge + 1), 64'(monE.lat));
          checkOutput("busy_at_done", 64'(busy_o), 64'd0);
          lastProd = monE.prod;
        end
      end else if (sbQ.size() > 0) begin
        checkOutput("busy_in_run", 64'(busy_o), 64'd1);
        checkOutput("product_held", product_o, lastProd);
      end
    end
    prevDone = done_o;
  end

  initial begin
    int waitCyc;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_done", 64'(done_o), 64'd0);
    checkOutput("reset_product", product_o, 64'd0);
    rst_n = 1'b1;

    applyStimulus(32'd16, 32'd15, 64'd240);
    applyStimulus(32'd36, 32'd63, 64'd2268);
    applyStimulus(32'd131072, 32'd131072, 64'h0000_0004_0000_0000);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(32'd0, 32'd12345, 64'd0);
    applyStimulus(32'd12345, 32'd0, 64'd0);
    applyStimulus(32'd32, 32'd0, 64'd0);

    applyStimulus(32'd4, 32'd4, 64'd16);
    repeat (3) begin
      @(negedge clk);
      if (busy_o) begin
        a_i = 32'd255;
        b_i = 32'd15;
        start_i = 1'b1;
      end
      @(negedge clk);
      start_i = 1'b0;
    end

    applyStimulus(32'd31, 32'd65536, 64'd2031616);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy_o), 64'd0);
    checkOutput("abort_done", 64'(done_o), 64'd0);
    checkOutput("abort_product", product_o, 64'd0);
    sbQ.delete();
    lastProd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    applyStimulus(32'd31, 32'd65536, 64'd2031616);
    applyStimulus(32'd7, 32'd1, 64'd7);

    waitCyc = 0;
    while (sbQ.size() > 0 && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
